desc_sche_app_ctrl: RTL and testbench
=====================================

Name: desc_sche_app_ctrl

Overview:
Per-application token controller that feeds the descriptor scheduler's PIFO.
- Tracks the descriptor backlog of each app ID held in the queue manager.
- Keeps exactly one scheduling token per backlogged app: the token is either pending or resident in the PIFO.
- Pushes tokens (app ID plus configured priority) into the PIFO, re-arms a token after each pop while backlog remains, and drives the PIFO eligibility mask.

Parameters:
APP_ID_WIDTH, 4, app ID width; NUM_APP = 2**APP_ID_WIDTH tracked apps (16, matching the PIFO depth).
PRIO_WIDTH, 4, priority field width pushed to the PIFO.
CNT_WIDTH, 16, per-app backlog counter width.

Ports:
clk  in  1  clock
rst  in  1  reset
enq_valid  in  1  queue manager accepted one descriptor for enq_app_id
enq_app_id  in  APP_ID_WIDTH  app of the enqueued descriptor
deq_valid  in  1  PIFO token popped (scheduler issued a descriptor request) for deq_app_id
deq_app_id  in  APP_ID_WIDTH  app of the popped token
m_pifo_valid  out  1  token push valid
m_pifo_prio  out  PRIO_WIDTH  token priority
m_pifo_data  out  APP_ID_WIDTH  token app ID
m_pifo_ready  in  1  PIFO accepts push
m_pifo_empty  out  1  one-cycle pulse: app backlog reached zero
m_pifo_empty_data  out  APP_ID_WIDTH  app ID for m_pifo_empty
m_app_mask  out  NUM_APP  bit i = cfg_enable[i] and count[i] != 0
cfg_wr_en  in  1  configuration write strobe
cfg_app_id  in  APP_ID_WIDTH  app being configured
cfg_prio  in  PRIO_WIDTH  new priority
cfg_enable  in  1  new enable bit
err_overflow  out  1  sticky: enqueue at saturated count
err_underflow  out  1  sticky: dequeue with zero count or no token outstanding

Behaviour:
Clock and reset (decided):
- Single clock, clk.
- rst is synchronous and active-high.

Reset values:
- count[] = 0, pending[] = 0, token_out[] = 0, prio[] = 0, enable[] = all 1, rr_ptr = 0.
- m_pifo_valid = 0, m_pifo_prio = 0, m_pifo_data = 0.
- m_pifo_empty = 0, m_pifo_empty_data = 0.
- m_app_mask = 0, err_overflow = 0, err_underflow = 0.
- Reset mid-operation discards all counts and tokens. The outstanding push is dropped even if m_pifo_valid was high.

Counters:
- Per-app count[] with enqueue +1 and dequeue -1.
- Enqueue and dequeue to the same app in the same cycle: count unchanged.
- Enqueue when count = 2**CNT_WIDTH-1: count held, err_overflow set.
- Dequeue when count = 0 or the app holds no token: count held, err_underflow set, no token action.

Token rules (per app, evaluated on post-update count):
- An enqueue that takes count from 0 to nonzero, while the app has no token, sets pending.
- Dequeue clears token_out. If the post-update count is nonzero, set pending. If it is zero, pulse m_pifo_empty with m_pifo_empty_data = app on the next cycle.
- Invariant: count != 0 implies exactly one of pending or token_out is set.

Push slot (single output register, valid/ready):
- The slot is free when m_pifo_valid = 0 or (m_pifo_valid and m_pifo_ready).
- When free, select one app with pending and enable set, per the selection policy. Load m_pifo_data = app and m_pifo_prio = prio[app], assert valid, clear pending, set token_out.
- Outputs stay stable while valid and not ready.
- Latency: enqueue on an empty app in cycle N gives m_pifo_valid in cycle N+2 if the slot is free.
- A re-armed token after dequeue in cycle N also gives m_pifo_valid in cycle N+2.
- Back-to-back pushes reach one per cycle while ready is held high.

Default selection policy:
- Round-robin starting at rr_ptr.
- After each grant, rr_ptr = granted + 1, modulo NUM_APP.

Enable and configuration:
- Apps with enable = 0 keep pending but are never selected.
- cfg_wr_en updates prio and enable at the next edge.
- A token already in the slot or in the PIFO keeps its old priority. The new priority applies to the next push.
- m_app_mask is registered and reflects post-update count and enable one cycle after the event.

Optional Feature:
RL_SCHE_PRIO_SELECT_EN
- Defined: the push-slot selection grants the pending, enabled app with the numerically lowest prio[]. Ties go to the lowest app ID. rr_ptr is unused.
- Undefined: round-robin as above.
- Token rules, latency and all ports are identical in both builds.

Test Plan:
1. Reset; enq app 3 once in cycle 0 -> m_pifo_valid = 1, data = 3, prio = 0 in cycle 2; m_app_mask = 0x0008 in cycle 1.
2. Enq app 5 three times, then three deq app 5 each after its push -> exactly 3 pushes of 5 and 2 re-arms. After the third deq: m_pifo_empty pulse with data = 5, mask bit 5 = 0.
3. Pending apps 1, 2 and 7 with m_pifo_ready held 0 for 5 cycles -> valid held and data stable at 1. After ready: pushes 1, 2, 7 on consecutive cycles (round-robin). With RL_SCHE_PRIO_SELECT_EN and prio = {1:3, 2:1, 7:0}: pushes 7, 2, 1.
4. Same-cycle enq and deq app 4 with count = 1 -> count stays 1, token re-armed, push of 4 two cycles later, no empty pulse.
5. cfg disable app 6 with pending set -> no push of 6 and mask bit 6 = 0. Re-enable -> push of 6 within 2 cycles.
6. Deq app 9 with count 0 -> err_underflow = 1 and stays set. Enq at count 0xFFFF -> err_overflow = 1, count stays 0xFFFF.

Source files
------------

// File: rtl/desc_sche_app_ctrl.sv
// Per-app token controller feeding the descriptor scheduler PIFO: backlog counters, one token per backlogged app.
// Optional macro RL_SCHE_PRIO_SELECT_EN: push slot grants lowest prio value (ties to lowest ID) instead of round-robin.
module desc_sche_app_ctrl #(
    parameter int unsigned APP_ID_WIDTH = 4,
    parameter int unsigned PRIO_WIDTH   = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid,
    input  logic [APP_ID_WIDTH-1:0]       enq_app_id,
    input  logic                          deq_valid,
    input  logic [APP_ID_WIDTH-1:0]       deq_app_id,
    output logic                          m_pifo_valid,
    output logic [PRIO_WIDTH-1:0]         m_pifo_prio,
    output logic [APP_ID_WIDTH-1:0]       m_pifo_data,
    input  logic                          m_pifo_ready,
    output logic                          m_pifo_empty,
    output logic [APP_ID_WIDTH-1:0]       m_pifo_empty_data,
    output logic [(2**APP_ID_WIDTH)-1:0]  m_app_mask,
    input  logic                          cfg_wr_en,
    input  logic [APP_ID_WIDTH-1:0]       cfg_app_id,
    input  logic [PRIO_WIDTH-1:0]         cfg_prio,
    input  logic                          cfg_enable,
    output logic                          err_overflow,
    output logic                          err_underflow
);
    localparam int unsigned NUM_APP = 2**APP_ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]    count     [NUM_APP];
    logic [CNT_WIDTH-1:0]    count_nxt [NUM_APP];
    logic [PRIO_WIDTH-1:0]   prio      [NUM_APP];
    logic [NUM_APP-1:0]      pending, token_out, enable;
    logic [NUM_APP-1:0]      pending_nxt, token_nxt, enable_nxt, mask_nxt;
    logic [NUM_APP-1:0]      inc_vec, dec_vec, eligible;
    logic                    enq_ovf, deq_ok, deq_unf, empty_nxt, slot_free;
    logic                    grant_vld;
    logic [APP_ID_WIDTH-1:0] grant_id;

    assign eligible = pending & enable;

`ifdef RL_SCHE_PRIO_SELECT_EN
    logic [PRIO_WIDTH-1:0] best_prio;

    // Lowest prio value wins; strict compare keeps the lowest app ID on ties.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        best_prio = '1;
        for (int k = 0; k < int'(NUM_APP); k++) begin
            if (eligible[k] && (!grant_vld || (prio[k] < best_prio))) begin
                grant_vld = 1'b1;
                grant_id  = APP_ID_WIDTH'(k);
                best_prio = prio[k];
            end
        end
    end
`else
    logic [APP_ID_WIDTH-1:0] rr_ptr;

    // Scan downward so the eligible app closest to rr_ptr is the last, winning assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = int'(NUM_APP) - 1; k >= 0; k--) begin
            if (eligible[rr_ptr + APP_ID_WIDTH'(k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr + APP_ID_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (slot_free && grant_vld) begin
            rr_ptr <= grant_id + APP_ID_WIDTH'(1);
        end
    end
`endif

    // Counter and token bookkeeping on post-update counts.
    always_comb begin
        enq_ovf     = enq_valid && (count[enq_app_id] == CNT_MAX);
        deq_ok      = deq_valid && (count[deq_app_id] != '0) && token_out[deq_app_id];
        deq_unf     = deq_valid && !deq_ok;
        slot_free   = !m_pifo_valid || m_pifo_ready;
        pending_nxt = pending;
        token_nxt   = token_out;
        enable_nxt  = enable;
        empty_nxt   = 1'b0;
        inc_vec     = '0;
        dec_vec     = '0;
        mask_nxt    = '0;
        for (int i = 0; i < int'(NUM_APP); i++) begin
            inc_vec[i]   = enq_valid && !enq_ovf && (enq_app_id == APP_ID_WIDTH'(i));
            dec_vec[i]   = deq_ok && (deq_app_id == APP_ID_WIDTH'(i));
            count_nxt[i] = count[i] + CNT_WIDTH'(inc_vec[i]) - CNT_WIDTH'(dec_vec[i]);
            if (inc_vec[i] && (count[i] == '0) && !token_out[i]) begin
                pending_nxt[i] = 1'b1;
            end
            if (dec_vec[i]) begin
                token_nxt[i] = 1'b0;
                if (count_nxt[i] != '0) begin
                    pending_nxt[i] = 1'b1;
                end else begin
                    empty_nxt = 1'b1;
                end
            end
        end
        if (slot_free && grant_vld) begin
            pending_nxt[grant_id] = 1'b0;
            token_nxt[grant_id]   = 1'b1;
        end
        if (cfg_wr_en) begin
            enable_nxt[cfg_app_id] = cfg_enable;
        end
        for (int i = 0; i < int'(NUM_APP); i++) begin
            mask_nxt[i] = enable_nxt[i] && (count_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_APP); i++) begin
                count[i] <= '0;
                prio[i]  <= '0;
            end
            pending           <= '0;
            token_out         <= '0;
            enable            <= '1;
            m_pifo_valid      <= 1'b0;
            m_pifo_prio       <= '0;
            m_pifo_data       <= '0;
            m_pifo_empty      <= 1'b0;
            m_pifo_empty_data <= '0;
            m_app_mask        <= '0;
            err_overflow      <= 1'b0;
            err_underflow     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_APP); i++) begin
                count[i] <= count_nxt[i];
            end
            pending    <= pending_nxt;
            token_out  <= token_nxt;
            enable     <= enable_nxt;
            m_app_mask <= mask_nxt;
            if (cfg_wr_en) begin
                prio[cfg_app_id] <= cfg_prio;
            end
            // Push slot holds its payload while the PIFO back-pressures.
            if (slot_free) begin
                m_pifo_valid <= grant_vld;
                if (grant_vld) begin
                    m_pifo_data <= grant_id;
                    m_pifo_prio <= prio[grant_id];
                end
            end
            m_pifo_empty <= empty_nxt;
            if (empty_nxt) begin
                m_pifo_empty_data <= deq_app_id;
            end
            if (enq_ovf) begin
                err_overflow <= 1'b1;
            end
            if (deq_unf) begin
                err_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_desc_sche_app_ctrl.sv
// Testbench for desc_sche_app_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_desc_sche_app_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 4;
    localparam int NA = 16;
    localparam int CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid, deq_valid, m_pifo_ready, cfg_wr_en, cfg_enable;
    logic [AW-1:0] enq_app_id, deq_app_id, cfg_app_id;
    logic [PW-1:0] cfg_prio;
    logic          m_pifo_valid, m_pifo_empty, err_overflow, err_underflow;
    logic [PW-1:0] m_pifo_prio;
    logic [AW-1:0] m_pifo_data, m_pifo_empty_data;
    logic [NA-1:0] m_app_mask;

    always #5 clk = ~clk;

    desc_sche_app_ctrl dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_app_id(enq_app_id),
        .deq_valid(deq_valid), .deq_app_id(deq_app_id),
        .m_pifo_valid(m_pifo_valid), .m_pifo_prio(m_pifo_prio), .m_pifo_data(m_pifo_data),
        .m_pifo_ready(m_pifo_ready),
        .m_pifo_empty(m_pifo_empty), .m_pifo_empty_data(m_pifo_empty_data),
        .m_app_mask(m_app_mask),
        .cfg_wr_en(cfg_wr_en), .cfg_app_id(cfg_app_id), .cfg_prio(cfg_prio), .cfg_enable(cfg_enable),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: per-app backlog, token location and the expected output registers.
    int cnt [NA];
    bit pend [NA];
    bit tok [NA];
    bit en [NA];
    int pr [NA];
    int rr;
    bit e_valid, e_empty, e_ovf, e_unf;
    int e_data, e_prio, e_edata;
    int pifo [$];
    int push_log [$];

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            cnt[i] = 0; pend[i] = 0; tok[i] = 0; en[i] = 1; pr[i] = 0;
        end
        rr = 0; e_valid = 0; e_data = 0; e_prio = 0; e_empty = 0; e_edata = 0;
        e_ovf = 0; e_unf = 0;
        pifo.delete();
    endfunction

    function automatic int pick();
        int g = -1;
`ifdef RL_SCHE_PRIO_SELECT_EN
        for (int i = 0; i < NA; i++)
            if (pend[i] && en[i] && (g < 0 || pr[i] < pr[g])) g = i;
`else
        for (int k = 0; k < NA; k++) begin
            int a = (rr + k) % NA;
            if (g < 0 && pend[a] && en[a]) g = a;
        end
`endif
        return g;
    endfunction

    function automatic bit has_tok(input int a);
        foreach (pifo[i]) if (pifo[i] == a) return 1;
        return 0;
    endfunction

    function automatic int mask_exp();
        int m = 0;
        for (int i = 0; i < NA; i++) if (en[i] && cnt[i] != 0) m |= (1 << i);
        return m;
    endfunction

    function automatic void model_step();
        bit free;
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        free = !e_valid || m_pifo_ready;
        g = free ? pick() : -1;
        if (e_valid && m_pifo_ready) pifo.push_back(e_data);
        e_empty = 0;
        if (enq_valid) begin
            int a = int'(enq_app_id);
            if (cnt[a] == CMAX) e_ovf = 1;
            else begin
                if (cnt[a] == 0 && !tok[a]) pend[a] = 1;
                cnt[a]++;
            end
        end
        if (deq_valid) begin
            int d = int'(deq_app_id);
            if (cnt[d] == 0 || !tok[d]) e_unf = 1;
            else begin
                cnt[d]--;
                tok[d] = 0;
                foreach (pifo[i]) if (pifo[i] == d) begin pifo.delete(i); break; end
                if (cnt[d] != 0) pend[d] = 1;
                else begin e_empty = 1; e_edata = d; end
            end
        end
        if (g >= 0) begin
            e_valid = 1; e_data = g; e_prio = pr[g];
            pend[g] = 0; tok[g] = 1; rr = (g + 1) % NA;
        end else if (free) begin
            e_valid = 0;
        end
        if (cfg_wr_en) begin
            pr[int'(cfg_app_id)] = int'(cfg_prio);
            en[int'(cfg_app_id)] = cfg_enable;
        end
    endfunction

    task automatic check_outputs();
        chk("valid", m_pifo_valid, e_valid);
        if (e_valid) begin
            chk("data", m_pifo_data, e_data);
            chk("prio", m_pifo_prio, e_prio);
        end
        chk("empty", m_pifo_empty, e_empty);
        if (e_empty) chk("empty_data", m_pifo_empty_data, e_edata);
        chk("mask", m_app_mask, mask_exp());
        chk("ovf", err_overflow, e_ovf);
        chk("unf", err_underflow, e_unf);
    endtask

    task automatic tick(input bit do_chk);
        if (m_pifo_valid && m_pifo_ready) push_log.push_back(int'(m_pifo_data));
        @(posedge clk);
        model_step();
        #1;
        if (do_chk) check_outputs();
        enq_valid = 0; deq_valid = 0; cfg_wr_en = 0;
    endtask

    task automatic enq(input int a);
        enq_valid = 1; enq_app_id = AW'(a); tick(1);
    endtask

    task automatic deq(input int a);
        deq_valid = 1; deq_app_id = AW'(a); tick(1);
    endtask

    task automatic cfg(input int a, input int p, input bit e);
        cfg_wr_en = 1; cfg_app_id = AW'(a); cfg_prio = PW'(p); cfg_enable = e; tick(1);
    endtask

    task automatic wait_tok(input int a);
        int n = 0;
        while (!has_tok(a) && n < 20) begin tick(1); n++; end
        chk("wait_tok", has_tok(a), 1);
    endtask

    initial begin
        int n5;
        int exp3 [4];
        rst = 1; enq_valid = 0; deq_valid = 0; cfg_wr_en = 0; cfg_enable = 1;
        enq_app_id = '0; deq_app_id = '0; cfg_app_id = '0; cfg_prio = '0; m_pifo_ready = 1;
        model_reset();
        tick(1); tick(1);
        rst = 0;

        // 1: first push latency and mask
        enq(3);
        chk("t1_mask", m_app_mask, 32'h0008);
        tick(1);
        chk("t1_valid", m_pifo_valid, 1);
        chk("t1_data", m_pifo_data, 3);
        chk("t1_prio", m_pifo_prio, 0);

        // 2: three descriptors, three pushes, then empty pulse
        push_log.delete();
        enq(5); enq(5); enq(5);
        for (int r = 0; r < 3; r++) begin wait_tok(5); deq(5); end
        chk("t2_empty", m_pifo_empty, 1);
        chk("t2_empty_data", m_pifo_empty_data, 5);
        chk("t2_mask5", m_app_mask[5], 0);
        tick(1);
        n5 = 0;
        foreach (push_log[i]) if (push_log[i] == 5) n5++;
        chk("t2_pushes", n5, 3);

        // 3: back-pressure then selection order
        cfg(1, 3, 1); cfg(2, 1, 1); cfg(7, 0, 1);
        m_pifo_ready = 0;
        enq(0); tick(1);
        enq(1); enq(2); enq(7);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("t3_hold_valid", m_pifo_valid, 1);
            chk("t3_hold_data", m_pifo_data, 0);
        end
        push_log.delete();
        m_pifo_ready = 1;
        for (int c = 0; c < 6; c++) tick(1);
`ifdef RL_SCHE_PRIO_SELECT_EN
        exp3 = '{0, 7, 2, 1};
`else
        exp3 = '{0, 1, 2, 7};
`endif
        chk("t3_npush", push_log.size(), 4);
        if (push_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t3_order", push_log[i], exp3[i]);

        // 4: same-cycle enq and deq keeps count, re-arms token
        enq(4); wait_tok(4);
        enq_valid = 1; enq_app_id = AW'(4); deq_valid = 1; deq_app_id = AW'(4);
        tick(1);
        chk("t4_no_empty", m_pifo_empty, 0);
        tick(1);
        chk("t4_valid", m_pifo_valid, 1);
        chk("t4_data", m_pifo_data, 4);

        // 5: disabled app keeps pending but is never pushed
        cfg(6, 0, 0);
        enq(6);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("t5_nopush", (m_pifo_valid && m_pifo_data == 4'd6), 0);
        end
        chk("t5_mask6", m_app_mask[6], 0);
        cfg(6, 0, 1);
        tick(1);
        chk("t5_valid", m_pifo_valid, 1);
        chk("t5_data", m_pifo_data, 6);

        // 6: underflow and overflow stickiness
        deq(9);
        chk("t6_unf", err_underflow, 1);
        tick(1); tick(1);
        chk("t6_unf_sticky", err_underflow, 1);
        for (int c = 0; c < CMAX; c++) begin
            enq_valid = 1; enq_app_id = AW'(10); tick(0);
        end
        check_outputs();
        chk("t6_no_ovf", err_overflow, 0);
        enq(10);
        chk("t6_ovf", err_overflow, 1);
        chk("t6_mask10", m_app_mask[10], 1);
        wait_tok(10); deq(10);
        tick(1);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            m_pifo_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) begin
                enq_valid = 1; enq_app_id = AW'($urandom_range(NA - 1));
            end
            if (pifo.size() > 0 && $urandom_range(2) == 0) begin
                deq_valid = 1; deq_app_id = AW'(pifo[$urandom_range(pifo.size() - 1)]);
            end
            if ($urandom_range(19) == 0) begin
                cfg_wr_en = 1; cfg_app_id = AW'($urandom_range(NA - 1));
                cfg_prio = PW'($urandom_range(15)); cfg_enable = ($urandom_range(3) != 0);
            end
            tick(1);
        end

        // Mid-operation reset drops everything, including a held push
        m_pifo_ready = 0;
        enq_valid = 1; enq_app_id = AW'(2);
        rst = 1;
        tick(1);
        rst = 0;
        chk("rst_valid", m_pifo_valid, 0);
        chk("rst_mask", m_app_mask, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_unf", err_underflow, 0);
        m_pifo_ready = 1;
        enq(11); tick(1);
        chk("rst_after_data", m_pifo_data, 11);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
